// File: rtl/peak_detector_pkg.sv
// Shared MCA definitions: bin address width, default ADC sample width and
// the peak-detector FSM state encoding.
package mca_pkg;

    localparam int unsigned BIN_W     = 10;
    localparam int unsigned ADC_W_DEF = 12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRACK,
        S_EMIT,
        S_STROBE,
        S_DRAIN
    } pd_state_t;

endpackage

// File: rtl/peak_detector_if.sv
// Sample-in / bin-out bus of the peak detector.
//   adc_data, adc_valid : ADC sample stream (qualified by adc_valid)
//   bin_addr, bin_we    : histogram RAM increment request
// master: the side that feeds samples and consumes bin writes.
// slave : the peak detector itself.
interface peak_detector_if
    import mca_pkg::*;
#(
    parameter int unsigned ADC_W = ADC_W_DEF
);

    logic [ADC_W-1:0] adc_data;
    logic             adc_valid;
    logic [BIN_W-1:0] bin_addr;
    logic             bin_we;

    modport master (
        output adc_data,
        output adc_valid,
        input  bin_addr,
        input  bin_we
    );

    modport slave (
        input  adc_data,
        input  adc_valid,
        output bin_addr,
        output bin_we
    );

endinterface

// File: rtl/peak_detector_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
//   clk   : clock
//   rst   : synchronous reset, clears count
//   inc   : increment request, ignored once count is all ones
//   count : current value, never wraps
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/peak_detector.sv
// Pulse-height analyzer feeding the histogram RAM. Finds pulses at or above
// threshold, captures the peak and issues one bin increment per accepted
// pulse; rejects overrange and pile-up (over-long) pulses.
//   clk, rst   : clock, synchronous active-high reset
//   en         : analysis enable; low aborts TRACK/DRAIN and blocks new pulses
//   threshold  : pulse threshold, static while busy
//   bus        : sample stream in, bin_addr/bin_we out
//   busy       : registered "FSM not in IDLE"
//   event_cnt  : accepted pulses (saturating)
//   reject_cnt : rejected pulses (saturating)
module peak_detector
    import mca_pkg::*;
#(
    parameter int unsigned ADC_W   = ADC_W_DEF,
    parameter int unsigned MAX_LEN = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [ADC_W-1:0] threshold,
    peak_detector_if.slave   bus,
    output logic             busy,
    output logic [31:0]      event_cnt,
    output logic [15:0]      reject_cnt
);

    localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

    pd_state_t        state, state_nxt;
    logic [ADC_W-1:0] peak, peak_nxt;
    logic [LEN_W-1:0] len, len_nxt, len_inc;
    logic [BIN_W-1:0] addr_q, addr_nxt;
    logic             we_q;
    logic             above, below;
    logic             reject;

    assign above   = bus.adc_valid && (bus.adc_data >= threshold);
    assign below   = bus.adc_valid && (bus.adc_data <  threshold);
    assign len_inc = len + LEN_W'(1);

    always_comb begin
        state_nxt = state;
        peak_nxt  = peak;
        len_nxt   = len;
        addr_nxt  = addr_q;
        reject    = 1'b0;
        case (state)
            S_IDLE: begin
                if (en && above) begin
                    state_nxt = S_TRACK;
                    peak_nxt  = bus.adc_data;
                    len_nxt   = LEN_W'(1);
                end
            end
            S_TRACK: begin
                if (!en) begin
                    state_nxt = S_IDLE;
                end else if (above) begin
                    peak_nxt = (bus.adc_data > peak) ? bus.adc_data : peak;
                    len_nxt  = len_inc;
                    if (len_inc == LEN_W'(MAX_LEN)) begin
                        reject    = 1'b1;
                        state_nxt = S_DRAIN;
                    end
                end else if (below) begin
                    if (peak == '1) begin
                        reject    = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        addr_nxt  = peak[ADC_W-1 -: BIN_W];
                        state_nxt = S_EMIT;
                    end
                end
            end
            S_EMIT:   state_nxt = S_STROBE;
            S_STROBE: state_nxt = S_IDLE;
            S_DRAIN: begin
                if (!en || below) begin
                    state_nxt = S_IDLE;
                end
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    // bin_we and busy are decoded from the next state so they are registered
    // and line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            peak   <= '0;
            len    <= '0;
            addr_q <= '0;
            we_q   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_nxt;
            peak   <= peak_nxt;
            len    <= len_nxt;
            addr_q <= addr_nxt;
            we_q   <= (state_nxt == S_STROBE);
            busy   <= (state_nxt != S_IDLE);
        end
    end

    assign bus.bin_addr = addr_q;
    assign bus.bin_we   = we_q;

    sat_counter #(.W(32)) u_event_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (state == S_STROBE),
        .count (event_cnt)
    );

    sat_counter #(.W(16)) u_reject_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (reject),
        .count (reject_cnt)
    );

endmodule

// File: tb/tb_peak_detector.sv
module tb_peak_detector;

    logic        clk;
    logic        rst;
    logic        en;
    logic [11:0] threshold;
    logic        busy;
    logic [31:0] event_cnt;
    logic [15:0] reject_cnt;

    logic        sat_rst;
    logic        sat_inc;
    logic [3:0]  sat_cnt;

    int n_cmp;
    int n_err;

    // strobe monitor state
    int          we_cnt;
    int          low_run;
    int          min_gap;
    logic        seen_we;
    logic        addr_ok;
    logic [9:0]  prev_addr;
    logic [9:0]  addr_log [0:7];

    peak_detector_if #(.ADC_W(12)) bus ();

    peak_detector #(.ADC_W(12), .MAX_LEN(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .threshold  (threshold),
        .bus        (bus),
        .busy       (busy),
        .event_cnt  (event_cnt),
        .reject_cnt (reject_cnt)
    );

    sat_counter #(.W(4)) u_sat (
        .clk   (clk),
        .rst   (sat_rst),
        .inc   (sat_inc),
        .count (sat_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (bus.bin_we === 1'b1) begin
            if (bus.bin_addr !== prev_addr) addr_ok = 1'b0;
            if (seen_we && (low_run < min_gap)) min_gap = low_run;
            if (we_cnt < 8) addr_log[we_cnt] = bus.bin_addr;
            we_cnt  = we_cnt + 1;
            low_run = 0;
            seen_we = 1'b1;
        end else begin
            low_run = low_run + 1;
        end
        prev_addr = bus.bin_addr;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [11:0] d);
        bus.adc_valid = v;
        bus.adc_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 12'd0);
    endtask

    task automatic clear_mon();
        we_cnt  = 0;
        low_run = 0;
        min_gap = 99;
        seen_we = 1'b0;
        addr_ok = 1'b1;
        for (int i = 0; i < 8; i++) addr_log[i] = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        clear_mon();
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        rst           = 1'b1;
        en            = 1'b1;
        threshold     = 12'd100;
        bus.adc_valid = 1'b0;
        bus.adc_data  = '0;
        sat_rst       = 1'b1;
        sat_inc       = 1'b0;
        prev_addr     = '0;
        clear_mon();

        // reset state
        do_reset();
        check("rst_addr",   32'(bus.bin_addr), 32'd0);
        check("rst_we",     32'(bus.bin_we),   32'd0);
        check("rst_busy",   32'(busy),         32'd0);
        check("rst_event",  event_cnt,         32'd0);
        check("rst_reject", 32'(reject_cnt),   32'd0);

        // basic pulse with exact strobe timing
        step(1'b1, 12'd50);
        check("basic_busy_below", 32'(busy), 32'd0);
        step(1'b1, 12'd200);
        check("basic_busy_track", 32'(busy), 32'd1);
        step(1'b1, 12'd800);
        step(1'b1, 12'd400);
        step(1'b1, 12'd50);
        check("basic_t_addr", 32'(bus.bin_addr), 32'd200);
        check("basic_t_we",   32'(bus.bin_we),   32'd0);
        step(1'b0, 12'd0);
        check("basic_t1_we",    32'(bus.bin_we), 32'd1);
        check("basic_t1_event", event_cnt,       32'd0);
        step(1'b0, 12'd0);
        check("basic_t2_we",    32'(bus.bin_we), 32'd0);
        check("basic_t2_event", event_cnt,       32'd1);
        check("basic_t2_busy",  32'(busy),       32'd0);
        idle(2);
        check("basic_we_cnt",  32'(we_cnt),      32'd1);
        check("basic_addr",    32'(addr_log[0]), 32'd200);
        check("basic_reject",  32'(reject_cnt),  32'd0);
        check("basic_addr_ok", 32'(addr_ok),     32'd1);

        // overrange
        do_reset();
        step(1'b1, 12'd50);
        step(1'b1, 12'd4095);
        check("ovr_busy", 32'(busy), 32'd1);
        step(1'b1, 12'd50);
        check("ovr_reject",    32'(reject_cnt), 32'd1);
        check("ovr_busy_done", 32'(busy),       32'd0);
        idle(3);
        check("ovr_we_cnt", 32'(we_cnt),  32'd0);
        check("ovr_event",  event_cnt,    32'd0);

        // pile-up
        do_reset();
        for (int i = 0; i < 63; i++) step(1'b1, 12'd300);
        check("pile_reject_63", 32'(reject_cnt), 32'd0);
        check("pile_busy_63",   32'(busy),       32'd1);
        step(1'b1, 12'd300);
        check("pile_reject_64", 32'(reject_cnt), 32'd1);
        check("pile_busy_drain", 32'(busy),      32'd1);
        step(1'b1, 12'd300);
        check("pile_reject_drain", 32'(reject_cnt), 32'd1);
        step(1'b1, 12'd70);
        check("pile_busy_idle", 32'(busy), 32'd0);
        check("pile_we_none",   32'(we_cnt), 32'd0);
        step(1'b1, 12'd500);
        step(1'b1, 12'd50);
        idle(3);
        check("pile_next_we",     32'(we_cnt),      32'd1);
        check("pile_next_addr",   32'(addr_log[0]), 32'd125);
        check("pile_next_event",  event_cnt,        32'd1);
        check("pile_next_reject", 32'(reject_cnt),  32'd1);

        // gapped valid, then threshold-equal samples
        do_reset();
        step(1'b1, 12'd50);  idle(3);
        step(1'b1, 12'd200); idle(3);
        step(1'b1, 12'd800); idle(3);
        step(1'b1, 12'd400); idle(3);
        step(1'b1, 12'd50);  idle(3);
        check("gap_we_cnt", 32'(we_cnt),      32'd1);
        check("gap_addr",   32'(addr_log[0]), 32'd200);
        check("gap_event",  event_cnt,        32'd1);
        check("gap_reject", 32'(reject_cnt),  32'd0);
        step(1'b1, 12'd100); idle(3);
        step(1'b1, 12'd100); idle(3);
        step(1'b1, 12'd99);  idle(3);
        check("eq_we_cnt", 32'(we_cnt),      32'd2);
        check("eq_addr",   32'(addr_log[1]), 32'd25);
        check("eq_event",  event_cnt,        32'd2);

        // enable dropped mid-TRACK, and en low blocks a new pulse
        do_reset();
        step(1'b1, 12'd200);
        step(1'b1, 12'd300);
        check("abort_busy_track", 32'(busy), 32'd1);
        en = 1'b0;
        step(1'b0, 12'd0);
        check("abort_busy", 32'(busy), 32'd0);
        step(1'b1, 12'd500);
        check("abort_en_low_idle", 32'(busy), 32'd0);
        en = 1'b1;
        step(1'b1, 12'd50);
        idle(3);
        check("abort_we_cnt", 32'(we_cnt),     32'd0);
        check("abort_event",  event_cnt,       32'd0);
        check("abort_reject", 32'(reject_cnt), 32'd0);

        // reset asserted during STROBE
        do_reset();
        step(1'b1, 12'd200); step(1'b1, 12'd50); idle(3);
        step(1'b1, 12'd4095); step(1'b1, 12'd50);
        check("pre_rst_event",  event_cnt,       32'd1);
        check("pre_rst_reject", 32'(reject_cnt), 32'd1);
        step(1'b1, 12'd200);
        step(1'b1, 12'd50);
        step(1'b0, 12'd0);
        check("strobe_we_before_rst", 32'(bus.bin_we), 32'd1);
        rst = 1'b1;
        step(1'b0, 12'd0);
        check("strobe_rst_we",     32'(bus.bin_we),   32'd0);
        check("strobe_rst_event",  event_cnt,         32'd0);
        check("strobe_rst_reject", 32'(reject_cnt),   32'd0);
        check("strobe_rst_busy",   32'(busy),         32'd0);
        check("strobe_rst_addr",   32'(bus.bin_addr), 32'd0);
        rst = 1'b0;

        // back-to-back pulses: samples during EMIT/STROBE are discarded
        do_reset();
        step(1'b1, 12'd200);
        step(1'b1, 12'd50);
        step(1'b1, 12'd300);
        step(1'b1, 12'd50);
        step(1'b1, 12'd300);
        step(1'b1, 12'd50);
        idle(4);
        check("b2b_we_cnt",  32'(we_cnt),      32'd2);
        check("b2b_addr0",   32'(addr_log[0]), 32'd50);
        check("b2b_addr1",   32'(addr_log[1]), 32'd75);
        check("b2b_min_gap", 32'(min_gap),     32'd3);
        check("b2b_event",   event_cnt,        32'd2);
        check("b2b_addr_ok", 32'(addr_ok),     32'd1);

        // counter saturation on a narrow instance
        sat_rst = 1'b1;
        @(posedge clk); #1;
        sat_rst = 1'b0;
        check("sat_rst", 32'(sat_cnt), 32'd0);
        sat_inc = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
        end
        check("sat_14", 32'(sat_cnt), 32'd14);
        @(posedge clk); #1;
        check("sat_15", 32'(sat_cnt), 32'd15);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("sat_hold", 32'(sat_cnt), 32'd15);
        sat_inc = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
